// File: rtl/iob_pwq_pkg.sv
// Shared definitions for the posted-write queue: FSM state encoding and queue entry layout.
// An entry is packed as {address, lower strobe, upper strobe}.
package iob_pwq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WREQ = 3'd1,
        ST_WACT = 3'd2,
        ST_RREQ = 3'd3,
        ST_RACT = 3'd4
    } state_t;

    localparam int ENT_FLAGS = 2;
    localparam int ENT_L_BIT = 1;
    localparam int ENT_U_BIT = 0;

    function automatic int entry_w(input int aw);
        return aw + ENT_FLAGS;
    endfunction

endpackage

// File: rtl/iob_pwq_if.sv
// Bundle of FSB-side and IO-master-side signals of the posted-write queue.
// slave is the queue's view, master is the view of whatever drives it (FSB slave plus IO master).
interface iob_pwq_if #(
    parameter int AW = 23
);
    logic          PW_VALID;
    logic [AW-1:0] PW_A;
    logic          PW_L;
    logic          PW_U;
    logic          PW_READY;
    logic          RD_VALID;
    logic [AW-1:0] RD_A;
    logic          RD_L;
    logic          RD_U;
    logic          RD_DONE;
    logic          EMPTY;
    logic          IORDREQ;
    logic          IOWRREQ;
    logic [AW-1:0] IOA;
    logic          IOL0;
    logic          IOU0;
    logic          IOACT;
    logic          IODONE;
    logic          IOBERR;
    logic          PWERR;
    logic [AW-1:0] PWERR_A;

    modport slave (
        input  PW_VALID, PW_A, PW_L, PW_U,
        input  RD_VALID, RD_A, RD_L, RD_U,
        input  IOACT, IODONE, IOBERR,
        output PW_READY, RD_DONE, EMPTY,
        output IORDREQ, IOWRREQ, IOA, IOL0, IOU0,
        output PWERR, PWERR_A
    );

    modport master (
        output PW_VALID, PW_A, PW_L, PW_U,
        output RD_VALID, RD_A, RD_L, RD_U,
        output IOACT, IODONE, IOBERR,
        input  PW_READY, RD_DONE, EMPTY,
        input  IORDREQ, IOWRREQ, IOA, IOL0, IOU0,
        input  PWERR, PWERR_A
    );

endinterface

// File: rtl/iob_pwq_ram.sv
// DEPTH x W register file for queued posted writes: one synchronous write port,
// asynchronous read of the head entry.
module iob_pwq_ram #(
    parameter int DEPTH = 2,
    parameter int W     = 25,
    parameter int PTRW  = 1
) (
    input  logic            clk_i,
    input  logic            we_i,
    input  logic [PTRW-1:0] waddr_i,
    input  logic [W-1:0]    wdata_i,
    input  logic [PTRW-1:0] raddr_i,
    output logic [W-1:0]    rdata_o
);

    // No reset: validity is tracked by the pointers and count in the parent.
    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/iob_pwq.sv
// Posted-write queue and IO request arbiter: queues FSB IO writes, serialises them onto the
// IO master handshake, and issues reads only once all earlier writes have completed.
// Optional macro IOB_PWQ_BERR_EN adds a sticky posted-write bus-error flag with first-error address.
module iob_pwq
    import iob_pwq_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = 23
) (
    input  logic     FCLK,
    input  logic     RES,
    iob_pwq_if.slave bus
);

    localparam int EW   = entry_w(AW);
    localparam int PTRW = $clog2(DEPTH);
    localparam int CW   = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    state_t          state_q, state_d;
    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            pw_ready_q, pw_ready_d;
    logic [AW-1:0]   ioa_q, ioa_d;
    logic            iol_q, iol_d;
    logic            iou_q, iou_d;

    logic            push;
    logic            pop;
    logic            load_wr;
    logic            load_rd;
    logic            iowrreq;
    logic            iordreq;
    logic            rd_done;
    logic            empty;
    logic [EW-1:0]   wr_entry;
    logic [EW-1:0]   head_entry;

    assign push     = bus.PW_VALID && pw_ready_q;
    assign wr_entry = {bus.PW_A, bus.PW_L, bus.PW_U};

    iob_pwq_ram #(
        .DEPTH (DEPTH),
        .W     (EW),
        .PTRW  (PTRW)
    ) u_ram (
        .clk_i   (FCLK),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (head_entry)
    );

    always_ff @(posedge FCLK) begin
        if (RES) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Writes always win over a pending read; IOACT with IODONE in a REQ state completes at once.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    state_d = ST_WREQ;
                end else if (bus.RD_VALID) begin
                    state_d = ST_RREQ;
                end
            end
            ST_WREQ: begin
                if (bus.IOACT) begin
                    state_d = bus.IODONE ? ST_IDLE : ST_WACT;
                end
            end
            ST_WACT: begin
                if (bus.IODONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RREQ: begin
                if (bus.IOACT) begin
                    state_d = bus.IODONE ? ST_IDLE : ST_RACT;
                end
            end
            ST_RACT: begin
                if (bus.IODONE) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        iowrreq = (state_q == ST_WREQ);
        iordreq = (state_q == ST_RREQ);
        load_wr = (state_q == ST_IDLE) && (count_q != '0);
        load_rd = (state_q == ST_IDLE) && (count_q == '0) && bus.RD_VALID;
        pop     = ((state_q == ST_WACT) && bus.IODONE) ||
                  ((state_q == ST_WREQ) && bus.IOACT && bus.IODONE);
        rd_done = ((state_q == ST_RACT) && bus.IODONE) ||
                  ((state_q == ST_RREQ) && bus.IOACT && bus.IODONE);
        empty   = (count_q == '0) && (state_q != ST_WREQ) && (state_q != ST_WACT);
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTRW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTRW'(1) : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        pw_ready_d = (count_d < FULL_CNT);
    end

    // Request attributes are latched at issue and held until the cycle completes.
    always_comb begin
        ioa_d = ioa_q;
        iol_d = iol_q;
        iou_d = iou_q;
        if (load_wr) begin
            ioa_d = head_entry[EW-1:ENT_FLAGS];
            iol_d = head_entry[ENT_L_BIT];
            iou_d = head_entry[ENT_U_BIT];
        end else if (load_rd) begin
            ioa_d = bus.RD_A;
            iol_d = bus.RD_L;
            iou_d = bus.RD_U;
        end
    end

    always_ff @(posedge FCLK) begin
        if (RES) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pw_ready_q <= 1'b1;
            ioa_q      <= '0;
            iol_q      <= 1'b0;
            iou_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            pw_ready_q <= pw_ready_d;
            ioa_q      <= ioa_d;
            iol_q      <= iol_d;
            iou_q      <= iou_d;
        end
    end

    assign bus.PW_READY = pw_ready_q;
    assign bus.EMPTY    = empty;
    assign bus.RD_DONE  = rd_done;
    assign bus.IOWRREQ  = iowrreq;
    assign bus.IORDREQ  = iordreq;
    assign bus.IOA      = ioa_q;
    assign bus.IOL0     = iol_q;
    assign bus.IOU0     = iou_q;

`ifdef IOB_PWQ_BERR_EN
    // Any completing posted write, including one finished in the same cycle as IOACT.
    logic          pwerr_q, pwerr_d;
    logic [AW-1:0] pwerr_a_q, pwerr_a_d;

    always_comb begin
        pwerr_d   = pwerr_q;
        pwerr_a_d = pwerr_a_q;
        if (pop && bus.IOBERR) begin
            pwerr_d = 1'b1;
            if (!pwerr_q) begin
                pwerr_a_d = ioa_q;
            end
        end
    end

    always_ff @(posedge FCLK) begin
        if (RES) begin
            pwerr_q   <= 1'b0;
            pwerr_a_q <= '0;
        end else begin
            pwerr_q   <= pwerr_d;
            pwerr_a_q <= pwerr_a_d;
        end
    end

    assign bus.PWERR   = pwerr_q;
    assign bus.PWERR_A = pwerr_a_q;
`else
    logic unused_berr;
    assign unused_berr = bus.IOBERR;
    assign bus.PWERR   = 1'b0;
    assign bus.PWERR_A = '0;
`endif

endmodule

// File: tb/tb_iob_pwq.sv
// Self-checking bench for iob_pwq: transaction-level queue model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_iob_pwq;

    localparam int DEPTH = 2;
    localparam int AW    = 23;

    logic clk = 1'b0;
    logic res;

    always #5 clk = ~clk;

    iob_pwq_if #(.AW(AW)) bus ();

    iob_pwq #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .FCLK (clk),
        .RES  (res),
        .bus  (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: list of uncompleted writes and the one request on the IO bus
    typedef struct packed {
        logic [AW-1:0] a;
        logic          l;
        logic          u;
    } ent_t;
    typedef enum int {K_NONE, K_WR, K_RD} kind_t;

    ent_t          m_q[$];
    ent_t          m_cur;
    kind_t         m_kind  = K_NONE;
    bit            m_taken = 1'b0;
    bit            m_perr  = 1'b0;
    logic [AW-1:0] m_perr_a = '0;
    bit            m_live  = 1'b0;

    initial forever begin : model
        bit   do_push;
        ent_t in_ent;
        @(posedge clk);
        if (res) begin
            m_q.delete();
            m_kind   = K_NONE;
            m_taken  = 1'b0;
            m_perr   = 1'b0;
            m_perr_a = '0;
            m_live   = 1'b1;
        end else begin
            do_push = bus.PW_VALID && (m_q.size() < DEPTH);
            in_ent  = '{a: bus.PW_A, l: bus.PW_L, u: bus.PW_U};
            if (m_kind == K_NONE) begin
                if (m_q.size() > 0) begin
                    m_kind = K_WR;
                    m_cur  = m_q[0];
                end else if (bus.RD_VALID) begin
                    m_kind = K_RD;
                    m_cur  = '{a: bus.RD_A, l: bus.RD_L, u: bus.RD_U};
                end
                m_taken = 1'b0;
            end else if ((m_taken || bus.IOACT) && bus.IODONE) begin
                if (m_kind == K_WR) begin
`ifdef IOB_PWQ_BERR_EN
                    if (bus.IOBERR && !m_perr) begin
                        m_perr   = 1'b1;
                        m_perr_a = m_cur.a;
                    end
`endif
                    void'(m_q.pop_front());
                end
                m_kind  = K_NONE;
                m_taken = 1'b0;
            end else if (bus.IOACT) begin
                m_taken = 1'b1;
            end
            if (do_push) m_q.push_back(in_ent);
        end
    end

    initial forever begin : compare
        @(negedge clk);
        if (m_live && !res) begin
            chk("m_iowrreq", 32'(bus.IOWRREQ), 32'(m_kind == K_WR && !m_taken));
            chk("m_iordreq", 32'(bus.IORDREQ), 32'(m_kind == K_RD && !m_taken));
            chk("m_rd_done", 32'(bus.RD_DONE),
                32'(m_kind == K_RD && (m_taken || bus.IOACT) && bus.IODONE));
            chk("m_empty", 32'(bus.EMPTY), 32'(m_q.size() == 0));
            chk("m_pw_ready", 32'(bus.PW_READY), 32'(m_q.size() < DEPTH));
            chk("m_pwerr", 32'(bus.PWERR), 32'(m_perr));
            chk("m_pwerr_a", 32'(bus.PWERR_A), 32'(m_perr_a));
            if (m_kind != K_NONE) begin
                chk("m_ioa", 32'(bus.IOA), 32'(m_cur.a));
                chk("m_iol0", 32'(bus.IOL0), 32'(m_cur.l));
                chk("m_iou0", 32'(bus.IOU0), 32'(m_cur.u));
            end
        end
    end

    // ---------------- stimulus helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push2(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        bus.PW_VALID = 1'b1;
        bus.PW_A     = a0;
        bus.PW_L     = 1'b1;
        bus.PW_U     = 1'b1;
        tick();
        bus.PW_A     = a1;
        tick();
        bus.PW_VALID = 1'b0;
    endtask

    // Wait (bounded) for a request, then take it and finish it.
    task automatic serve(input bit same_cycle, input bit berr);
        int n = 0;
        while (!(bus.IOWRREQ || bus.IORDREQ) && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            n_checks++;
            n_errors++;
            $display("FAIL serve_timeout: got no request, expected IOWRREQ or IORDREQ at %0t", $time);
            return;
        end
        bus.IOACT = 1'b1;
        if (same_cycle) begin
            bus.IODONE = 1'b1;
            bus.IOBERR = berr;
            tick();
            bus.IOACT  = 1'b0;
        end else begin
            tick();
            bus.IOACT  = 1'b0;
            bus.IODONE = 1'b1;
            bus.IOBERR = berr;
            tick();
        end
        bus.IODONE = 1'b0;
        bus.IOBERR = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        res          = 1'b1;
        bus.PW_VALID = 1'b0;
        bus.PW_A     = '0;
        bus.PW_L     = 1'b0;
        bus.PW_U     = 1'b0;
        bus.RD_VALID = 1'b0;
        bus.RD_A     = '0;
        bus.RD_L     = 1'b0;
        bus.RD_U     = 1'b0;
        bus.IOACT    = 1'b0;
        bus.IODONE   = 1'b0;
        bus.IOBERR   = 1'b0;
        tick();
        tick();
        chk("rst_pw_ready", 32'(bus.PW_READY), 1);
        chk("rst_empty", 32'(bus.EMPTY), 1);
        chk("rst_iowrreq", 32'(bus.IOWRREQ), 0);
        chk("rst_iordreq", 32'(bus.IORDREQ), 0);
        chk("rst_ioa", 32'(bus.IOA), 0);
        chk("rst_pwerr", 32'(bus.PWERR), 0);
        res = 1'b0;
        tick();

        // 1: single post
        bus.PW_VALID = 1'b1;
        bus.PW_A     = 23'h580000;
        bus.PW_L     = 1'b1;
        bus.PW_U     = 1'b0;
        tick();
        bus.PW_VALID = 1'b0;
        chk("s1_no_req_yet", 32'(bus.IOWRREQ), 0);
        chk("s1_not_empty", 32'(bus.EMPTY), 0);
        tick();
        chk("s1_iowrreq", 32'(bus.IOWRREQ), 1);
        chk("s1_ioa", 32'(bus.IOA), 32'h580000);
        chk("s1_iol0", 32'(bus.IOL0), 1);
        chk("s1_iou0", 32'(bus.IOU0), 0);
        bus.IOACT = 1'b1;
        tick();
        bus.IOACT = 1'b0;
        chk("s1_req_drop", 32'(bus.IOWRREQ), 0);
        chk("s1_ioa_hold", 32'(bus.IOA), 32'h580000);
        bus.IODONE = 1'b1;
        tick();
        bus.IODONE = 1'b0;
        chk("s1_empty", 32'(bus.EMPTY), 1);
        tick();

        // 2: fill, full stall, refused third post
        push2(23'h100, 23'h200);
        chk("s2_full", 32'(bus.PW_READY), 0);
        chk("s2_ioa_first", 32'(bus.IOA), 32'h100);
        bus.PW_VALID = 1'b1;
        bus.PW_A     = 23'h300;
        tick();
        bus.PW_VALID = 1'b0;
        chk("s2_still_full", 32'(bus.PW_READY), 0);
        bus.IOACT = 1'b1;
        tick();
        bus.IOACT  = 1'b0;
        bus.IODONE = 1'b1;
        tick();
        bus.IODONE = 1'b0;
        chk("s2_ready_back", 32'(bus.PW_READY), 1);
        tick();
        chk("s2_second_req", 32'(bus.IOWRREQ), 1);
        chk("s2_second_ioa", 32'(bus.IOA), 32'h200);
        serve(1'b1, 1'b0);
        chk("s2_third_dropped", 32'(bus.EMPTY), 1);
        tick();

        // 3: read waits behind posted writes
        push2(23'h10, 23'h20);
        bus.RD_VALID = 1'b1;
        bus.RD_A     = 23'h300;
        bus.RD_L     = 1'b1;
        bus.RD_U     = 1'b1;
        serve(1'b0, 1'b0);
        chk("s3_rd_blocked", 32'(bus.IORDREQ), 0);
        serve(1'b0, 1'b0);
        chk("s3_rd_blocked2", 32'(bus.IORDREQ), 0);
        tick();
        chk("s3_iordreq", 32'(bus.IORDREQ), 1);
        chk("s3_ioa", 32'(bus.IOA), 32'h300);
        bus.IOACT = 1'b1;
        tick();
        bus.IOACT  = 1'b0;
        bus.IODONE = 1'b1;
        #1;
        chk("s3_rd_done", 32'(bus.RD_DONE), 1);
        tick();
        bus.IODONE   = 1'b0;
        bus.RD_VALID = 1'b0;
        #1;
        chk("s3_rd_done_pulse", 32'(bus.RD_DONE), 0);
        tick();
        chk("s3_no_reissue", 32'(bus.IORDREQ), 0);

        // 4: IOACT and IODONE together in WREQ
        push2(23'h40, 23'h50);
        chk("s4_req", 32'(bus.IOWRREQ), 1);
        chk("s4_ioa", 32'(bus.IOA), 32'h40);
        bus.IOACT  = 1'b1;
        bus.IODONE = 1'b1;
        tick();
        bus.IOACT  = 1'b0;
        bus.IODONE = 1'b0;
        chk("s4_idle", 32'(bus.IOWRREQ), 0);
        chk("s4_ready", 32'(bus.PW_READY), 1);
        tick();
        chk("s4_next_req", 32'(bus.IOWRREQ), 1);
        chk("s4_next_ioa", 32'(bus.IOA), 32'h50);
        serve(1'b1, 1'b0);
        tick();

        // 5: reset in WACT with two entries
        push2(23'h60, 23'h70);
        bus.IOACT = 1'b1;
        tick();
        bus.IOACT = 1'b0;
        chk("s5_busy", 32'(bus.EMPTY), 0);
        chk("s5_full", 32'(bus.PW_READY), 0);
        res = 1'b1;
        tick();
        res = 1'b0;
        chk("s5_pw_ready", 32'(bus.PW_READY), 1);
        chk("s5_empty", 32'(bus.EMPTY), 1);
        chk("s5_iowrreq", 32'(bus.IOWRREQ), 0);
        chk("s5_ioa", 32'(bus.IOA), 0);
        chk("s5_iol0", 32'(bus.IOL0), 0);
        tick();
        tick();
        chk("s5_discarded", 32'(bus.IOWRREQ), 0);

        // 6: bus errors on posted writes
        push2(23'h400, 23'h500);
        serve(1'b0, 1'b1);
        serve(1'b0, 1'b1);
        tick();
        chk("s6_drained", 32'(bus.EMPTY), 1);
`ifdef IOB_PWQ_BERR_EN
        chk("s6_pwerr", 32'(bus.PWERR), 1);
        chk("s6_pwerr_a", 32'(bus.PWERR_A), 32'h400);
`else
        chk("s6_pwerr", 32'(bus.PWERR), 0);
        chk("s6_pwerr_a", 32'(bus.PWERR_A), 0);
`endif
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
